// File: rtl/spi_send_con.sv
// ============================================================================
// Module   : spi_send_con
// Purpose  : Multi-line SPI-style pixel transmitter. Words arrive on a
//            valid/ready handshake into a one-entry holding register. A
//            shifter then sends each word MS-first as BEATS groups of LINES
//            bits inside one active-low chip-select frame. Bit clock
//            half-period is CLK_DIV system cycles.
// Ports    : clk_in          - system clock
//            rst_in          - synchronous active-low reset
//            data_in         - pixel word
//            data_valid_in   - data_in valid
//            final_pixel_in  - marks last pixel of the video frame
//            data_ready_out  - holding register empty
//            chip_data_out   - data lines (MS group first)
//            chip_clk_out    - bit clock, idle low
//            chip_sel_out    - active-low frame select, idle high
//            final_pixel_out - high during the frame of a final pixel
//            busy_out        - shifter not idle
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_send_con #(
    parameter int DATA_WIDTH = 8,
    parameter int LINES      = 4,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid_in,
    input  logic                  final_pixel_in,
    output logic                  data_ready_out,
    output logic [LINES-1:0]      chip_data_out,
    output logic                  chip_clk_out,
    output logic                  chip_sel_out,
    output logic                  final_pixel_out,
    output logic                  busy_out
);

    localparam int BEATS  = DATA_WIDTH / LINES;
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [DIV_W-1:0]  C_DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BEAT_W-1:0] C_BEAT_LAST = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_HOLD  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    // Holding register
    logic [DATA_WIDTH-1:0] hold_word_q, hold_word_d;
    logic                  hold_last_q, hold_last_d;
    logic                  hold_full_q, hold_full_d;

    // Shifter
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  last_q, last_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [DIV_W-1:0]      div_q, div_d;

    // Output registers
    logic                  ready_q, ready_d;
    logic [LINES-1:0]      data_q, data_d;
    logic                  clk_q, clk_d;
    logic                  sel_q, sel_d;
    logic                  fp_q, fp_d;
    logic                  busy_q, busy_d;

    logic                  w_handshake;
    logic                  w_div_done;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_shift_next;

    assign w_handshake  = data_valid_in && ready_q;
    assign w_div_done   = (div_q == C_DIV_LAST);
    assign w_shift_next = shift_q << LINES;

    always_comb begin
        hold_word_d = hold_word_q;
        hold_last_d = hold_last_q;
        hold_full_d = hold_full_q;
        state_d     = state_q;
        shift_d     = shift_q;
        last_d      = last_q;
        beat_d      = beat_q;
        div_d       = div_q + DIV_W'(1);
        data_d      = data_q;
        w_load      = 1'b0;

        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (hold_full_q) begin
                    w_load = 1'b1;
                end
            end
            S_SETUP: begin
                if (w_div_done) begin
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (w_div_done) begin
                    if (beat_q != C_BEAT_LAST) begin
                        // Next group goes out on the falling edge
                        state_d = S_LOW;
                        beat_d  = beat_q + BEAT_W'(1);
                        shift_d = w_shift_next;
                        data_d  = w_shift_next[DATA_WIDTH-1 -: LINES];
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_LOW: begin
                if (w_div_done) begin
                    state_d = S_HIGH;
                end
            end
            S_HOLD: begin
                if (w_div_done) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (w_div_done) begin
                    if (hold_full_q) begin
                        w_load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_load) begin
            state_d     = S_SETUP;
            shift_d     = hold_word_q;
            last_d      = hold_last_q;
            beat_d      = '0;
            data_d      = hold_word_q[DATA_WIDTH-1 -: LINES];
            hold_full_d = 1'b0;
        end

        // Every state dwells CLK_DIV cycles measured from its entry
        if (state_d != state_q) begin
            div_d = '0;
        end

        // Capture needs ready (hold empty) and load needs hold full, so the
        // two never coincide.
        if (w_handshake) begin
            hold_word_d = data_in;
            hold_last_d = final_pixel_in;
            hold_full_d = 1'b1;
        end

        ready_d = !hold_full_d;
        sel_d   = !((state_d == S_SETUP) || (state_d == S_HIGH) ||
                    (state_d == S_LOW)   || (state_d == S_HOLD));
        clk_d   = (state_d == S_HIGH);
        fp_d    = !sel_d && last_d;
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            hold_word_q <= '0;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
            state_q     <= S_IDLE;
            shift_q     <= '0;
            last_q      <= 1'b0;
            beat_q      <= '0;
            div_q       <= '0;
            ready_q     <= 1'b1;
            data_q      <= '0;
            clk_q       <= 1'b0;
            sel_q       <= 1'b1;
            fp_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            hold_word_q <= hold_word_d;
            hold_last_q <= hold_last_d;
            hold_full_q <= hold_full_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            last_q      <= last_d;
            beat_q      <= beat_d;
            div_q       <= div_d;
            ready_q     <= ready_d;
            data_q      <= data_d;
            clk_q       <= clk_d;
            sel_q       <= sel_d;
            fp_q        <= fp_d;
            busy_q      <= busy_d;
        end
    end

    assign data_ready_out  = ready_q;
    assign chip_data_out   = data_q;
    assign chip_clk_out    = clk_q;
    assign chip_sel_out    = sel_q;
    assign final_pixel_out = fp_q;
    assign busy_out        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_send_con.sv
// ============================================================================
// Module   : tb_spi_send_con
// Purpose  : Self-checking bench for spi_send_con. Channel 0 uses default
//            parameters, channel 1 uses CLK_DIV=2, LINES=2. A line monitor
//            reassembles each select-low frame into a word, rise count,
//            length and final-pixel count, which the tests compare against
//            values derived from the link's framing rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_send_con;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       c0_rst = 1'b0, c0_valid = 1'b0, c0_last = 1'b0;
    logic [7:0] c0_data = 8'h00;
    logic       c0_ready, c0_cclk, c0_sel, c0_fp, c0_busy;
    logic [3:0] c0_cd;

    logic       c1_rst = 1'b0, c1_valid = 1'b0, c1_last = 1'b0;
    logic [7:0] c1_data = 8'h00;
    logic       c1_ready, c1_cclk, c1_sel, c1_fp, c1_busy;
    logic [1:0] c1_cd;

    spi_send_con dut0 (
        .clk_in(clk), .rst_in(c0_rst), .data_in(c0_data),
        .data_valid_in(c0_valid), .final_pixel_in(c0_last),
        .data_ready_out(c0_ready), .chip_data_out(c0_cd),
        .chip_clk_out(c0_cclk), .chip_sel_out(c0_sel),
        .final_pixel_out(c0_fp), .busy_out(c0_busy)
    );

    spi_send_con #(.DATA_WIDTH(8), .LINES(2), .CLK_DIV(2)) dut1 (
        .clk_in(clk), .rst_in(c1_rst), .data_in(c1_data),
        .data_valid_in(c1_valid), .final_pixel_in(c1_last),
        .data_ready_out(c1_ready), .chip_data_out(c1_cd),
        .chip_clk_out(c1_cclk), .chip_sel_out(c1_sel),
        .final_pixel_out(c1_fp), .busy_out(c1_busy)
    );

    typedef struct {
        int start;
        int len;
        int rises;
        int word;
        int fp;
    } frame_t;

    typedef struct {
        int word;
        bit last;
    } exp_t;

    frame_t fq0[$];
    frame_t fq1[$];
    frame_t cur[2];
    logic   psel[2] = '{1'b1, 1'b1};
    logic   pclk[2] = '{1'b0, 1'b0};
    int     cyc = 0;
    int     total = 0;
    int     bad = 0;

    // ------------------------------------------------------------------
    // Line monitor: samples 1 time unit after each rising clock edge.
    // ------------------------------------------------------------------
    task automatic mon(input int ch, input logic sel, input logic bclk,
                       input logic [3:0] d, input logic fp, input int lines);
        if (psel[ch] === 1'b1 && sel === 1'b0) begin
            cur[ch] = '{cyc, 0, 0, 0, 0};
        end
        if (sel === 1'b0) begin
            cur[ch].len++;
            if (fp === 1'b1) cur[ch].fp++;
            if (bclk === 1'b1 && pclk[ch] !== 1'b1) begin
                cur[ch].rises++;
                cur[ch].word = (cur[ch].word << lines) | int'(d);
            end
        end
        if (psel[ch] === 1'b0 && sel === 1'b1) begin
            if (ch == 0) fq0.push_back(cur[ch]);
            else         fq1.push_back(cur[ch]);
        end
        psel[ch] = sel;
        pclk[ch] = bclk;
    endtask

    always begin
        @(posedge clk);
        #1;
        cyc++;
        mon(0, c0_sel, c0_cclk, c0_cd, c0_fp, 4);
        mon(1, c1_sel, c1_cclk, {2'b00, c1_cd}, c1_fp, 2);
    end

    // ------------------------------------------------------------------
    // Stimulus utilities (drive / bounded waits, no comparisons of data)
    // ------------------------------------------------------------------
    function automatic logic rdy(input int ch);
        return (ch == 0) ? c0_ready : c1_ready;
    endfunction

    function automatic logic bsy(input int ch);
        return (ch == 0) ? c0_busy : c1_busy;
    endfunction

    function automatic int qsize(input int ch);
        return (ch == 0) ? fq0.size() : fq1.size();
    endfunction

    task automatic drive(input int ch, input logic v, input logic [7:0] d, input logic l);
        if (ch == 0) begin c0_valid = v; c0_data = d; c0_last = l; end
        else         begin c1_valid = v; c1_data = d; c1_last = l; end
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input int ch, input logic [7:0] d, input logic l,
                        input bit keep, output int hs);
        int n;
        n = 0;
        drive(ch, 1'b1, d, l);
        while (rdy(ch) !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        hs = cyc;
        total++;
        if (n >= 300) begin
            bad++;
            $display("FAIL send_timeout ch=%0d word=%02h: ready=0, required 1 within 300 cycles", ch, d);
        end
        @(negedge clk);
        if (!keep) drive(ch, 1'b0, d, 1'b0);
    endtask

    task automatic wait_frames(input int ch, input int n);
        int k;
        k = 0;
        while (qsize(ch) < n && k < 600) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (qsize(ch) < n) begin
            bad++;
            $display("FAIL frame_timeout ch=%0d: frames=%0d, required %0d", ch, qsize(ch), n);
        end
    endtask

    task automatic wait_idle(input int ch);
        int k;
        k = 0;
        while (bsy(ch) !== 1'b0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pop(input int ch, output frame_t f);
        f = '{-1, -1, -1, -1, -1};
        if (ch == 0 && fq0.size() > 0) f = fq0.pop_front();
        if (ch == 1 && fq1.size() > 0) f = fq1.pop_front();
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [8:0] obs0;
        logic [6:0] obs1;
        c0_rst = 1'b0;
        c1_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b1, 8'($urandom), 1'($urandom));
            drive(1, 1'b1, 8'($urandom), 1'($urandom));
            @(negedge clk);
            obs0 = {c0_sel, c0_cclk, c0_cd, c0_fp, c0_ready, c0_busy};
            obs1 = {c1_sel, c1_cclk, c1_cd, c1_fp, c1_ready, c1_busy};
            total++;
            if (obs0 !== 9'b1_0_0000_0_1_0) begin
                bad++;
                $display("FAIL reset_outputs_ch0 cyc=%0d: got %b, required 100000010", i, obs0);
            end
            total++;
            if (obs1 !== 7'b1_0_00_0_1_0) begin
                bad++;
                $display("FAIL reset_outputs_ch1 cyc=%0d: got %b, required 1000010", i, obs1);
            end
        end
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        c0_rst = 1'b1;
        c1_rst = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if ({c0_ready, c0_busy, c0_sel, c1_ready, c1_busy, c1_sel} !== 6'b101_101) begin
            bad++;
            $display("FAIL reset_no_handshake: ready/busy/sel=%b%b%b %b%b%b, required 101 101",
                     c0_ready, c0_busy, c0_sel, c1_ready, c1_busy, c1_sel);
        end
        total++;
        if (fq0.size() + fq1.size() != 0) begin
            bad++;
            $display("FAIL reset_no_frame: frames=%0d, required 0", fq0.size() + fq1.size());
        end
    endtask

    task automatic test_single();
        int hs;
        frame_t f;
        wait_idle(0);
        send(0, 8'hA5, 1'b0, 1'b0, hs);
        wait_frames(0, 1);
        pop(0, f);
        total++;
        if (f.start - hs != 2) begin
            bad++;
            $display("FAIL single_latency: sel fell %0d cycles after handshake, required 2", f.start - hs);
        end
        total++;
        if (f.len != 20) begin
            bad++;
            $display("FAIL single_sel_len: got %0d, required 20", f.len);
        end
        total++;
        if (f.rises != 2 || f.word != 'hA5) begin
            bad++;
            $display("FAIL single_data: rises=%0d word=%02h, required 2 / a5", f.rises, f.word);
        end
        total++;
        if (f.fp != 0) begin
            bad++;
            $display("FAIL single_fp: fp cycles=%0d, required 0", f.fp);
        end
    endtask

    task automatic test_back_to_back();
        int hs[3];
        logic [7:0] w[3] = '{8'h12, 8'h34, 8'h56};
        frame_t f[3];
        wait_idle(0);
        for (int i = 0; i < 3; i++) begin
            send(0, w[i], 1'b0, 1'b1, hs[i]);
            total++;
            if (c0_ready !== 1'b0) begin
                bad++;
                $display("FAIL b2b_ready_low word=%02h: ready=%b, required 0", w[i], c0_ready);
            end
        end
        drive(0, 1'b0, 8'h00, 1'b0);
        wait_frames(0, 3);
        for (int i = 0; i < 3; i++) pop(0, f[i]);
        total++;
        if (f[0].start - hs[0] != 2) begin
            bad++;
            $display("FAIL b2b_first_latency: got %0d, required 2", f[0].start - hs[0]);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (f[i].word != int'(w[i]) || f[i].rises != 2 || f[i].len != 20) begin
                bad++;
                $display("FAIL b2b_frame%0d: word=%02h rises=%0d len=%0d, required %02h/2/20",
                         i, f[i].word, f[i].rises, f[i].len, w[i]);
            end
            if (i > 0) begin
                total++;
                if (f[i].start - f[i-1].start != 24 || f[i].start - f[i-1].start - f[i-1].len != 4) begin
                    bad++;
                    $display("FAIL b2b_spacing%0d: period=%0d gap=%0d, required 24/4", i,
                             f[i].start - f[i-1].start, f[i].start - f[i-1].start - f[i-1].len);
                end
            end
        end
    endtask

    task automatic test_final_pixel();
        int hs;
        frame_t f0, f1;
        wait_idle(0);
        send(0, 8'h0F, 1'b1, 1'b1, hs);
        send(0, 8'hF0, 1'b0, 1'b0, hs);
        wait_frames(0, 2);
        pop(0, f0);
        pop(0, f1);
        total++;
        if (f0.fp != 20 || f0.len != 20 || f0.word != 'h0F) begin
            bad++;
            $display("FAIL final_first: fp=%0d len=%0d word=%02h, required 20/20/0f", f0.fp, f0.len, f0.word);
        end
        total++;
        if (f1.fp != 0 || f1.word != 'hF0) begin
            bad++;
            $display("FAIL final_second: fp=%0d word=%02h, required 0/f0", f1.fp, f1.word);
        end
    endtask

    task automatic test_mid_reset();
        int hs, hs2, k;
        frame_t f;
        wait_idle(0);
        send(0, 8'hC3, 1'b0, 1'b0, hs);
        send(0, 8'h99, 1'b1, 1'b0, hs2);
        k = 0;
        // Frame starts at hs+2; second HIGH occupies samples start+12..start+15
        while (cyc < hs + 2 + 13 && k < 100) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (c0_cclk !== 1'b1 || c0_sel !== 1'b0 || c0_ready !== 1'b0) begin
            bad++;
            $display("FAIL midrst_in_high: clk=%b sel=%b ready=%b, required 1/0/0", c0_cclk, c0_sel, c0_ready);
        end
        c0_rst = 1'b0;
        @(negedge clk);
        total++;
        if ({c0_sel, c0_cclk, c0_cd, c0_fp, c0_ready, c0_busy} !== 9'b1_0_0000_0_1_0) begin
            bad++;
            $display("FAIL midrst_outputs: got %b, required 100000010",
                     {c0_sel, c0_cclk, c0_cd, c0_fp, c0_ready, c0_busy});
        end
        c0_rst = 1'b1;
        fq0.delete();
        repeat (72) @(negedge clk);
        total++;
        if (fq0.size() != 0 || c0_busy !== 1'b0) begin
            bad++;
            $display("FAIL midrst_hold_dropped: frames=%0d busy=%b, required 0/0", fq0.size(), c0_busy);
        end
        send(0, 8'h77, 1'b0, 1'b0, hs);
        wait_frames(0, 1);
        pop(0, f);
        total++;
        if (f.word != 'h77 || f.rises != 2 || f.len != 20 || f.fp != 0 || f.start - hs != 2) begin
            bad++;
            $display("FAIL midrst_after: word=%02h rises=%0d len=%0d fp=%0d lat=%0d, required 77/2/20/0/2",
                     f.word, f.rises, f.len, f.fp, f.start - hs);
        end
    endtask

    task automatic test_param_sweep();
        int hs, hs2;
        logic [7:0] w2;
        frame_t f, g;
        w2 = 8'($urandom);
        wait_idle(1);
        send(1, 8'hB4, 1'b0, 1'b1, hs);
        send(1, w2, 1'b0, 1'b0, hs2);
        wait_frames(1, 2);
        pop(1, f);
        pop(1, g);
        total++;
        if (f.rises != 4 || f.word != 'hB4) begin
            bad++;
            $display("FAIL sweep_dibits: rises=%0d word=%02h, required 4/b4", f.rises, f.word);
        end
        total++;
        if (f.len != 18 || f.start - hs != 2) begin
            bad++;
            $display("FAIL sweep_sel: len=%0d lat=%0d, required 18/2", f.len, f.start - hs);
        end
        total++;
        if (g.start - f.start != 20 || g.word != int'(w2)) begin
            bad++;
            $display("FAIL sweep_frame_len: period=%0d word=%02h, required 20/%02h", g.start - f.start, g.word, w2);
        end
    endtask

    task automatic test_random(input int ch);
        exp_t   exp_q[$];
        exp_t   e;
        frame_t f;
        int     hs, beats, div, prev;
        logic [7:0] w;
        logic   l;
        beats = (ch == 0) ? 2 : 4;
        div   = (ch == 0) ? 4 : 2;
        wait_idle(ch);
        for (int i = 0; i < 8; i++) begin
            w = 8'($urandom);
            l = 1'($urandom);
            exp_q.push_back('{int'(w), l});
            send(ch, w, l, 1'($urandom_range(0, 1)), hs);
            drive(ch, 1'b0, 8'h00, 1'b0);
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        wait_frames(ch, 8);
        prev = -1000;
        for (int i = 0; i < 8; i++) begin
            pop(ch, f);
            e = exp_q.pop_front();
            total++;
            if (f.word != e.word || f.rises != beats || f.len != div * (2 * beats + 1) ||
                f.fp != (e.last ? div * (2 * beats + 1) : 0) ||
                f.start - prev < div * (2 * beats + 2)) begin
                bad++;
                $display("FAIL random_ch%0d_%0d: word=%02h rises=%0d len=%0d fp=%0d period=%0d, required %02h/%0d/%0d/%0d/>=%0d",
                         ch, i, f.word, f.rises, f.len, f.fp, f.start - prev, e.word, beats,
                         div * (2 * beats + 1), e.last ? div * (2 * beats + 1) : 0, div * (2 * beats + 2));
            end
            prev = f.start;
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_final_pixel();
        test_mid_reset();
        test_param_sweep();
        test_random(0);
        test_random(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
